// File: rtl/lap_recorder_if.sv
// Signal bundle between the stopwatch control/counter side and the lap recorder.
// The master side drives the control levels, the button pulses and the live time.
// The slave side (the recorder) returns display and status information.
interface lap_recorder_if #(
  parameter int TIME_W = 16,
  parameter int IDX_W  = 3
);
  logic              init_regs;
  logic              count_enabled;
  logic              split;
  logic              browse;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] disp_time;
  logic [IDX_W-1:0]  lap_sel;
  logic [IDX_W:0]    lap_count;
  logic              reviewing;
  logic              full;
  logic              rec_pulse;

  modport master (
    output init_regs, count_enabled, split, browse, time_in,
    input  disp_time, lap_sel, lap_count, reviewing, full, rec_pulse
  );

  modport slave (
    input  init_regs, count_enabled, split, browse, time_in,
    output disp_time, lap_sel, lap_count, reviewing, full, rec_pulse
  );
endinterface

// File: rtl/lap_recorder_ctl.sv
// Lap/split recorder and display scheduler.
// While counting, split pulses capture the live time into a small lap buffer.
// While stopped, browse pulses step the display through the stored laps.
// Otherwise the display follows the live time.
module lap_recorder_ctl #(
  parameter int TIME_W = 16,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic         clk,
  input  logic         reset,
  lap_recorder_if.slave bus
);

  typedef enum logic {
    LIVE   = 1'b0,
    REVIEW = 1'b1
  } state_e;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  lap_sel_q, lap_sel_d;
  logic [IDX_W:0]    lap_count_q, lap_count_d;
  logic              full_q, full_d;
  logic              rec_pulse_q, rec_pulse_d;
  logic [TIME_W-1:0] disp_time_q, disp_time_d;
  logic [TIME_W-1:0] mem_q [DEPTH];

  logic              rec_en;
  logic              last_lap;

  // Decide recording, FSM transitions, lap index and display value for the next cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    lap_sel_d   = lap_sel_q;
    lap_count_d = lap_count_q;
    rec_pulse_d = 1'b0;

    // A lap is stored only while counting, not idle, and with room left.
    rec_en   = bus.split && bus.count_enabled && !full_q && !bus.init_regs;
    last_lap = ({1'b0, lap_sel_q} == (lap_count_q - 1'b1));

    if (bus.init_regs) begin
      state_d     = LIVE;
      lap_sel_d   = '0;
      lap_count_d = '0;
    end else begin
      if (rec_en) begin
        lap_count_d = lap_count_q + 1'b1;
        rec_pulse_d = 1'b1;
      end

      unique case (state_q)
        LIVE: begin
          if (bus.browse && !bus.count_enabled && (lap_count_q != '0)) begin
            state_d   = REVIEW;
            lap_sel_d = '0;
          end
        end
        REVIEW: begin
          // Restarting the counter forces the live view and beats browse.
          if (bus.count_enabled) begin
            state_d   = LIVE;
            lap_sel_d = '0;
          end else if (bus.browse) begin
            if (last_lap) begin
              state_d   = LIVE;
              lap_sel_d = '0;
            end else begin
              lap_sel_d = lap_sel_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d   = LIVE;
          lap_sel_d = '0;
        end
      endcase
    end

    full_d = (lap_count_d == DEPTH_C);

    // Display uses the current state and index, independent of the next-state decision.
    disp_time_d = (state_q == REVIEW) ? mem_q[lap_sel_q] : bus.time_in;
  end

  // Control and display registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LIVE;
      lap_sel_q   <= '0;
      lap_count_q <= '0;
      full_q      <= 1'b0;
      rec_pulse_q <= 1'b0;
      disp_time_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q     <= state_d;
      lap_sel_q   <= lap_sel_d;
      lap_count_q <= lap_count_d;
      full_q      <= full_d;
      rec_pulse_q <= rec_pulse_d;
      disp_time_q <= disp_time_d;
    end
  end

  // Lap buffer write port; reset only blocks the write.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is not reset; unwritten entries are never displayed, so this lets it map to RAM.
    if (!reset && rec_en) begin
      mem_q[lap_count_q[IDX_W-1:0]] <= bus.time_in;
    end
  end

  assign bus.disp_time = disp_time_q;
  assign bus.lap_sel   = lap_sel_q;
  assign bus.lap_count = lap_count_q;
  assign bus.reviewing = (state_q == REVIEW);
  assign bus.full      = full_q;
  assign bus.rec_pulse = rec_pulse_q;

endmodule

// File: tb/tb_lap_recorder_ctl.sv
// Directed self-checking bench for lap_recorder_ctl.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_lap_recorder_ctl;

  localparam int TIME_W = 16;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  lap_recorder_if #(.TIME_W(TIME_W), .IDX_W(IDX_W)) bus ();

  lap_recorder_ctl #(.TIME_W(TIME_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_split();
    bus.split = 1'b1;
    tick();
    bus.split = 1'b0;
  endtask

  task automatic pulse_browse();
    bus.browse = 1'b1;
    tick();
    bus.browse = 1'b0;
  endtask

  initial begin
    logic [15:0] t2_vals [3];
    n_checks = 0;
    n_fail   = 0;
    t2_vals[0] = 16'h0011;
    t2_vals[1] = 16'h0042;
    t2_vals[2] = 16'h0107;

    bus.init_regs     = 1'b0;
    bus.count_enabled = 1'b0;
    bus.split         = 1'b0;
    bus.browse        = 1'b0;
    bus.time_in       = 16'h0;
    reset             = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_disp",  32'(bus.disp_time), 32'h0);
    chk("rst_sel",   32'(bus.lap_sel),   32'h0);
    chk("rst_cnt",   32'(bus.lap_count), 32'h0);
    chk("rst_rev",   32'(bus.reviewing), 32'h0);
    chk("rst_full",  32'(bus.full),      32'h0);
    chk("rst_pulse", 32'(bus.rec_pulse), 32'h0);

    // Test 1: live tracking with one cycle of latency
    reset       = 1'b0;
    bus.time_in = 16'h0123;
    tick();
    chk("t1_disp", 32'(bus.disp_time), 32'h0123);
    chk("t1_cnt",  32'(bus.lap_count), 32'h0);
    chk("t1_rev",  32'(bus.reviewing), 32'h0);

    // Test 2: three splits while counting
    bus.count_enabled = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.time_in = t2_vals[i];
      pulse_split();
      chk("t2_pulse", 32'(bus.rec_pulse), 32'h1);
      chk("t2_cnt",   32'(bus.lap_count), 32'(i + 1));
      tick();
      chk("t2_pulse_end", 32'(bus.rec_pulse), 32'h0);
    end
    chk("t2_full", 32'(bus.full), 32'h0);

    // Test 3: browse through three laps then back to live
    bus.count_enabled = 1'b0;
    bus.time_in       = 16'h9999;
    tick();
    chk("t3_live0", 32'(bus.disp_time), 32'h9999);
    for (int i = 0; i < 3; i++) begin
      pulse_browse();
      tick();
      chk("t3_rev",  32'(bus.reviewing), 32'h1);
      chk("t3_sel",  32'(bus.lap_sel),   32'(i));
      chk("t3_disp", 32'(bus.disp_time), 32'(t2_vals[i]));
    end
    pulse_browse();
    tick();
    chk("t3_back_rev",  32'(bus.reviewing), 32'h0);
    chk("t3_back_sel",  32'(bus.lap_sel),   32'h0);
    chk("t3_back_disp", 32'(bus.disp_time), 32'h9999);
    chk("t3_cnt_kept",  32'(bus.lap_count), 32'h3);

    // Split while stopped is ignored
    pulse_split();
    chk("stop_split_cnt",   32'(bus.lap_count), 32'h3);
    chk("stop_split_pulse", 32'(bus.rec_pulse), 32'h0);

    // Test 4: clear, then ten splits fill the buffer and saturate
    bus.init_regs = 1'b1;
    tick();
    bus.init_regs = 1'b0;
    chk("t4_clr_cnt", 32'(bus.lap_count), 32'h0);
    bus.count_enabled = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.time_in = 16'h1000 + 16'(i);
      pulse_split();
      chk("t4_pulse", 32'(bus.rec_pulse), (i < 8) ? 32'h1 : 32'h0);
      chk("t4_cnt",   32'(bus.lap_count), (i < 8) ? 32'(i + 1) : 32'h8);
      tick();
    end
    chk("t4_full", 32'(bus.full),      32'h1);
    chk("t4_cnt8", 32'(bus.lap_count), 32'h8);

    // Browse to entry 7: it must still hold the eighth value
    bus.count_enabled = 1'b0;
    bus.time_in       = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      pulse_browse();
    end
    tick();
    chk("t4_sel7",  32'(bus.lap_sel),   32'h7);
    chk("t4_mem7",  32'(bus.disp_time), 32'h1007);
    pulse_browse();
    chk("t4_wrap_rev", 32'(bus.reviewing), 32'h0);

    // Test 5: forced exit from REVIEW when counting resumes
    pulse_browse();
    pulse_browse();
    tick();
    chk("t5_sel1", 32'(bus.lap_sel),   32'h1);
    chk("t5_rev1", 32'(bus.reviewing), 32'h1);
    chk("t5_mem1", 32'(bus.disp_time), 32'h1001);
    bus.count_enabled = 1'b1;
    bus.time_in       = 16'h4321;
    bus.browse        = 1'b1;
    tick();
    bus.browse = 1'b0;
    chk("t5_rev", 32'(bus.reviewing), 32'h0);
    chk("t5_sel", 32'(bus.lap_sel),   32'h0);
    tick();
    chk("t5_disp", 32'(bus.disp_time), 32'h4321);

    // Test 6: clear with five laps; simultaneous browse ignored
    bus.init_regs = 1'b1;
    tick();
    bus.init_regs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.time_in = 16'h2000 + 16'(i);
      pulse_split();
    end
    chk("t6_cnt5", 32'(bus.lap_count), 32'h5);
    bus.count_enabled = 1'b0;
    bus.init_regs     = 1'b1;
    bus.browse        = 1'b1;
    tick();
    bus.init_regs = 1'b0;
    bus.browse    = 1'b0;
    chk("t6_cnt",  32'(bus.lap_count), 32'h0);
    chk("t6_full", 32'(bus.full),      32'h0);
    chk("t6_rev",  32'(bus.reviewing), 32'h0);

    // Browse with no laps is ignored
    pulse_browse();
    chk("empty_browse", 32'(bus.reviewing), 32'h0);

    // Reset during a record cycle suppresses it
    bus.count_enabled = 1'b1;
    bus.split         = 1'b1;
    reset             = 1'b1;
    tick();
    bus.split = 1'b0;
    reset     = 1'b0;
    chk("rst_rec_cnt",   32'(bus.lap_count), 32'h0);
    chk("rst_rec_pulse", 32'(bus.rec_pulse), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
